// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch-side PC owner: redirect arbitration, IROM req/gnt
//            sequencing and pipeline flush generation around the NPC adder.
//            Optional: PC_SEQ_EARLY_JUMP_EN honours ID-stage jal redirects.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] npc,
   input  logic        stall,
   input  logic        ex_redirect,
   input  logic [31:0] ex_target,
   input  logic        id_redirect,
   input  logic [31:0] id_target,
   input  logic        imem_gnt,
   output logic [31:0] pc,
   output logic        npc_flag,
   output logic [31:0] npc_change,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic        if_valid,
   output logic        flush_ifid,
   output logic        flush_idex
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_imem_req;
   logic        r_pend_valid;
   logic [31:0] r_pend_target;

   logic        w_id_redirect;
   logic [31:0] w_id_target;
   logic        w_redirect;
   logic        w_flag;
   logic [31:0] w_change;
   logic        w_flush_ifid;
   logic        w_flush_idex;
   logic        w_if_valid;

`ifdef PC_SEQ_EARLY_JUMP_EN
   assign w_id_redirect = id_redirect;
   assign w_id_target   = id_target;
`else
   // jal resolves in EX; the ID ports stay only for uniform wiring
   logic w_unused_id;
   assign w_unused_id   = ^{id_redirect, id_target};
   assign w_id_redirect = 1'b0;
   assign w_id_target   = 32'h0000_0000;
`endif

   assign w_redirect = ex_redirect | w_id_redirect;

   always_comb begin
      w_flag       = 1'b0;
      w_change     = 32'h0000_0000;
      w_flush_ifid = 1'b0;
      w_flush_idex = 1'b0;
      w_if_valid   = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (w_redirect) begin
               w_flag       = 1'b1;
               w_change     = ex_redirect ? ex_target : w_id_target;
               w_flush_ifid = 1'b1;
               w_flush_idex = ex_redirect;
            end
            w_if_valid = imem_gnt & ~w_redirect & ~stall;
         end
         S_DRAIN: begin
            // Wrong-path ID redirects are dropped; only EX may retarget.
            w_flag       = r_pend_valid | ex_redirect;
            w_change     = ex_redirect ? ex_target : r_pend_target;
            w_flush_ifid = ex_redirect;
            w_flush_idex = ex_redirect;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_BOOT;
         r_pc          <= RESET_PC;
         r_imem_req    <= 1'b0;
         r_pend_valid  <= 1'b0;
         r_pend_target <= 32'h0000_0000;
      end else begin
         case (r_state)
            S_BOOT: begin
               r_state    <= S_FETCH;
               r_imem_req <= 1'b1;
            end
            S_FETCH: begin
               if (imem_gnt) begin
                  if (w_redirect || !stall) begin
                     r_pc <= npc;
                  end
               end else if (w_redirect) begin
                  // Address must stay stable until gnt; park the target.
                  r_pend_valid  <= 1'b1;
                  r_pend_target <= w_change;
                  r_state       <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               r_pend_target <= w_change;
               if (imem_gnt) begin
                  r_pc         <= npc;
                  r_pend_valid <= 1'b0;
                  r_state      <= S_FETCH;
               end
            end
            default: begin
               r_state    <= S_BOOT;
               r_imem_req <= 1'b0;
            end
         endcase
      end
   end

   assign pc         = r_pc;
   assign imem_addr  = r_pc;
   assign imem_req   = r_imem_req;
   assign npc_flag   = w_flag;
   assign npc_change = w_change;
   assign if_valid   = w_if_valid;
   assign flush_ifid = w_flush_ifid;
   assign flush_idex = w_flush_idex;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller wrapping the next-PC adder: owns the PC register, drives the adder's `flag`/`npc_change` select, and arbitrates between redirect sources (EX-stage branch/jalr and ID-stage jal). Sequences instruction-memory fetches with a req/gnt handshake and issues pipeline flushes. Sits between the NPC adder, the IROM interface and the IF/ID register.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  core clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `npc`  in  32  next PC from adder (pc+4 or `npc_change`).
- `stall`  in  1  load-use hazard; IF/ID must hold.
- `ex_redirect`  in  1  EX-resolved taken branch / jalr.
- `ex_target`  in  32  EX redirect target.
- `id_redirect`  in  1  ID-decoded jal (see Configuration).
- `id_target`  in  32  ID redirect target.
- `imem_gnt`  in  1  instruction memory returns data for `imem_addr` this cycle.
- `pc`  out  32  current fetch PC (to adder and IF/ID).
- `npc_flag`  out  1  adder select: 1 = take `npc_change`.
- `npc_change`  out  32  redirect target to adder.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equals `pc`.
- `if_valid`  out  1  fetched instruction accepted into IF/ID this cycle.
- `flush_ifid`  out  1  kill IF/ID contents.
- `flush_idex`  out  1  kill ID/EX contents.

## Operation
- States: BOOT, FETCH, DRAIN. Registers: `pc`, `pend_valid`, `pend_target`.
- BOOT: entered on reset; `imem_req`=0; unconditionally to FETCH next cycle.
- Redirect select (combinational): `ex_redirect` beats `id_redirect`; selected target on `npc_change`, `npc_flag`=1. In DRAIN, a live `ex_redirect` beats `pend_target`; otherwise `pend_target` drives `npc_change` with `npc_flag`=1.
- FETCH, `imem_req`=1, `imem_addr`=`pc`:
  - gnt=1, no redirect, stall=0: commit; `if_valid`=1, `pc`<=`npc` (= pc+4).
  - gnt=1, no redirect, stall=1: `if_valid`=0, `pc` holds, same address re-requested.
  - gnt=1, redirect: `if_valid`=0, `pc`<=`npc` (= target); redirect overrides stall.
  - gnt=0, redirect: address must stay stable until gnt; latch target into `pend_*`, go DRAIN.
  - gnt=0, no redirect: hold.
- DRAIN: `imem_req`=1 at old `pc`; `if_valid`=0 always. New `ex_redirect` overwrites `pend_target`; `id_redirect` ignored (wrong path). On gnt: `pc`<=`npc`, clear `pend_valid`, return to FETCH. `stall` ignored.
- Flushes (combinational, same cycle as the accepted redirect input): `flush_ifid`=1 on any accepted redirect; `flush_idex`=1 on `ex_redirect` only. Ignored `id_redirect` in DRAIN raises neither.
- Arithmetic: 32-bit, pc+4 wraps 32'hFFFF_FFFC -> 0; targets used unaligned-as-is.

## Timing
- Reset values: `pc`=`RESET_PC`, `imem_req`=0, `if_valid`=0, `npc_flag`=0, `npc_change`=0, flushes 0, `pend_valid`=0, state BOOT.
- Reset mid-DRAIN/FETCH: immediate abort, pending discarded, no further `if_valid`.
- First request: cycle after reset release + 1 (BOOT cycle).
- Zero-wait memory: one instruction per cycle; redirect costs 1 bubble (no `if_valid` in redirect cycle).
- N-wait memory with redirect mid-wait: old fetch completes, discarded, target fetched next cycle.
- `npc_flag`/`npc_change` combinational from inputs and `pend_*`; `pc`, state registered.

## Configuration
- `PC_SEQ_EARLY_JUMP_EN` defined: `id_redirect`/`id_target` honoured as above (jal costs 1 bubble).
- Undefined: `id_redirect` ignored entirely; jal must be resolved in EX via `ex_redirect`; ports remain for uniform wiring.

## Test plan
- Reset, RESET_PC=0, gnt tied 1 -> `imem_addr` 0,4,8,0xC on consecutive cycles after BOOT, `if_valid`=1 each.
- `stall`=1 two cycles at pc=0x8 -> `pc` stays 0x8, `if_valid`=0 two cycles, then resumes 0xC.
- Same-cycle `ex_redirect`(0x100) + `id_redirect`(0x200) + `stall` at pc=0x10, gnt=1 -> next `pc`=0x100, both flushes 1, `if_valid`=0.
- gnt low 3 cycles, `id_redirect`(0x40) cycle 1, `ex_redirect`(0x80) cycle 2 -> `imem_addr` stays old pc, after gnt `pc`=0x80, old data not validated.
- `rst_n` pulsed low while in DRAIN -> outputs at reset values asynchronously, `pc`=RESET_PC, pending target never fetched.
- pc=0xFFFF_FFFC, gnt=1 -> next `pc`=0x0.
